my_project: RTL and testbench
=============================

MY_PROJECT -- requirements
Module: my_project

Interface
REQ-001 SHALL have parameter FP_TOTAL, default 16, the pixel and result word width.
REQ-002 SHALL have parameter OUT_ROWS, default 48, the cropped image height.
REQ-003 SHALL have parameter OUT_COLS, default 48, the cropped image width.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ap_start, input, 1 bit: frame start request.
REQ-007 SHALL have port ap_idle, output, 1 bit: block in IDLE.
REQ-008 SHALL have port ap_ready, output, 1 bit: last input pixel accepted.
REQ-009 SHALL have port ap_done, output, 1 bit: all results delivered.
REQ-010 SHALL have port conv2d_input_V_data_0_V_TDATA, input, FP_TOTAL bits: pixel, signed, integer.
REQ-011 SHALL have port conv2d_input_V_data_0_V_TVALID, input, 1 bit: pixel valid.
REQ-012 SHALL have port conv2d_input_V_data_0_V_TREADY, output, 1 bit: pixel ready.
REQ-013 SHALL have ports layer15_out_V_data_k_V_TDATA, k=0..4, output, FP_TOTAL bits each: result k.
REQ-014 SHALL have ports layer15_out_V_data_k_V_TVALID, k=0..4, output, 1 bit each: result k valid.
REQ-015 SHALL have ports layer15_out_V_data_k_V_TREADY, k=0..4, input, 1 bit each: result k ready.

Function
REQ-016 SHALL implement FSM IDLE->LOAD->DIVIDE->OUTPUT->IDLE; ap_idle=1 only in IDLE.
REQ-017 SHALL leave IDLE for LOAD when ap_start=1 at a clock edge; ap_start outside IDLE is ignored.
REQ-018 SHALL drive input TREADY=1 only in LOAD; a pixel is accepted on any edge with TVALID&TREADY.
REQ-019 SHALL take pixels in raster order (row 0..OUT_ROWS-1, col 0..OUT_COLS-1), exactly OUT_ROWS*OUT_COLS per frame.
REQ-020 SHALL clamp negative pixels to 0 (p) before accumulation.
REQ-021 SHALL accumulate: max p; S=sum p; Sr=sum r*p; Sc=sum c*p; Srr=sum r^2*p; Scc=sum c^2*p; all accumulators 40-bit unsigned, cleared on leaving IDLE.
REQ-022 SHALL pulse ap_ready one cycle on acceptance of the final pixel, then enter DIVIDE.
REQ-023 SHALL, in DIVIDE, compute unsigned floor quotients mr=Sr/S, mc=Sc/S, qr=Srr/S, qc=Scc/S sequentially on one shared divider (<=48 cycles each).
REQ-024 SHALL form results: out0=max p; out1=mr; out2=mc; out3=qr-mr^2; out4=qc-mc^2; negatives clamp to 0, values above 2^(FP_TOTAL-1)-1 saturate to it.
REQ-025 SHALL, when S=0, skip division and output 0 on all five streams.
REQ-026 SHALL, in OUTPUT, assert all five TVALIDs with stable TDATA; each stream deasserts TVALID independently after its own TVALID&TREADY edge.
REQ-027 SHALL pulse ap_done one cycle when the last of the five outputs is accepted and return to IDLE in the same edge.
REQ-028 SHALL accept ap_start on the cycle after ap_done; each result is delivered exactly once per frame.

Reset
REQ-029 SHALL, with ap_rst_n=0, immediately enter IDLE: ap_idle=1; ap_done, ap_ready, input TREADY, all output TVALIDs=0; all output TDATA=0; accumulators and counters=0.
REQ-030 SHALL abort any in-progress frame on reset; partial data is discarded and no output is produced.

Structure
REQ-031 SHALL place FP_TOTAL-derived widths, the accumulator width (40), the state enum and the result-index constants in shared package my_project_pkg.
REQ-032 SHALL use one sub-module, seq_divider: 40-bit dividend, 40-bit divisor, start/busy/done handshake, restoring algorithm, one quotient bit per cycle.

Verification
REQ-033 SHALL verify: pixel 100 at (10,20), all others 0 -> outputs 100,10,20,0,0.
REQ-034 SHALL verify: all-zero frame -> outputs 0,0,0,0,0; ap_done asserts.
REQ-035 SHALL verify: 50 at (0,0) and at (0,2), others 0 -> outputs 50,0,1,0,1.
REQ-036 SHALL verify: all pixels -5 except 7 at (47,47) -> outputs 7,47,47,0,0.
REQ-037 SHALL verify: REQ-033 frame under random 50% input TVALID and output TREADY -> identical outputs; exactly 2304 pixels accepted; one ap_ready pulse; one ap_done pulse.
REQ-038 SHALL verify: reset asserted after 1000 pixels, then a fresh REQ-035 frame -> outputs 50,0,1,0,1; ap_start pulsed during LOAD is ignored.

Source files
------------

// File: rtl/my_project_pkg.sv
// Shared constants, widths and types for the my_project centroid/spread engine.
// Imported by the top, the divider and the divider bus interface.
package my_project_pkg;

    localparam int FP_TOTAL_DEF = 16;
    localparam int ACC_W        = 40;
    localparam int CNT_W        = 16;
    localparam int DIV_CNT_W    = $clog2(ACC_W + 1);
    // Signed width holding an ACC_W square plus sign, used for the spread terms.
    localparam int WIDE_W       = 2 * ACC_W + 2;

    localparam int NUM_RES = 5;
    localparam int RES_MAX = 0;
    localparam int RES_MR  = 1;
    localparam int RES_MC  = 2;
    localparam int RES_VR  = 3;
    localparam int RES_VC  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DIVIDE = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/my_project_if.sv
// Bus between the frame controller and the shared sequential divider.
// Handshake: start is honoured only while busy=0; done pulses one cycle with quotient valid, held until the next start.
interface my_project_if;
    import my_project_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] dividend;
    logic [ACC_W-1:0] divisor;
    logic [ACC_W-1:0] quotient;

    modport master (output start, dividend, divisor, input busy, done, quotient);
    modport slave  (input start, dividend, divisor, output busy, done, quotient);

endinterface

// File: rtl/my_project_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, ACC_W cycles per divide.
// Operands are latched on start; the quotient register shifts the dividend out as result bits shift in.
module seq_divider
    import my_project_pkg::*;
(
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    my_project_if.slave  bus
);

    logic [ACC_W-1:0]     rem_q;
    logic [ACC_W-1:0]     quo_q;
    logic [ACC_W-1:0]     dvs_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [ACC_W:0]       shifted;
    logic [ACC_W-1:0]     diff;
    logic                 fits;

    always_comb begin
        shifted = {rem_q, quo_q[ACC_W-1]};
        fits    = shifted >= {1'b0, dvs_q};
        // When fits, the true remainder is below the divisor so the low bits are exact.
        diff    = shifted[ACC_W-1:0] - dvs_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                rem_q <= fits ? diff : shifted[ACC_W-1:0];
                quo_q <= {quo_q[ACC_W-2:0], fits};
                cnt_q <= cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (bus.start) begin
                rem_q  <= '0;
                quo_q  <= bus.dividend;
                dvs_q  <= bus.divisor;
                cnt_q  <= DIV_CNT_W'(ACC_W);
                busy_q <= 1'b1;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.quotient = quo_q;

endmodule

// File: rtl/my_project.sv
// Frame statistics engine: accumulates clamped pixel moments over a cropped frame, then
// reports peak, mean row/col and row/col spread on five independent AXI-stream outputs.
module my_project
    import my_project_pkg::*;
#(
    parameter int FP_TOTAL = FP_TOTAL_DEF,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic [FP_TOTAL-1:0] conv2d_input_V_data_0_V_TDATA,
    input  logic                conv2d_input_V_data_0_V_TVALID,
    output logic                conv2d_input_V_data_0_V_TREADY,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_0_V_TDATA,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_1_V_TDATA,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_2_V_TDATA,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_3_V_TDATA,
    output logic [FP_TOTAL-1:0] layer15_out_V_data_4_V_TDATA,
    output logic                layer15_out_V_data_0_V_TVALID,
    output logic                layer15_out_V_data_1_V_TVALID,
    output logic                layer15_out_V_data_2_V_TVALID,
    output logic                layer15_out_V_data_3_V_TVALID,
    output logic                layer15_out_V_data_4_V_TVALID,
    input  logic                layer15_out_V_data_0_V_TREADY,
    input  logic                layer15_out_V_data_1_V_TREADY,
    input  logic                layer15_out_V_data_2_V_TREADY,
    input  logic                layer15_out_V_data_3_V_TREADY,
    input  logic                layer15_out_V_data_4_V_TREADY,
    output state_t              dbg_state
);

    localparam logic signed [WIDE_W-1:0] SAT_V =
        {{(WIDE_W - FP_TOTAL + 1){1'b0}}, {(FP_TOTAL - 1){1'b1}}};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     row_q, col_q;
    logic [ACC_W-1:0]     max_q, s_q, sr_q, sc_q, srr_q, scc_q;
    logic [ACC_W-1:0]     mr_q, mc_q, qr_q;
    logic [1:0]           div_idx_q;
    logic                 div_wait_q;
    logic                 div_start;
    logic [FP_TOTAL-1:0]  out_data_q [NUM_RES];
    logic [FP_TOTAL-1:0]  res_d      [NUM_RES];
    logic [NUM_RES-1:0]   out_valid_q, out_valid_d, out_ready, out_fire;
    logic                 pix_fire, last_pix, row_last, col_last, s_zero;
    logic [FP_TOTAL-1:0]  pix_p;
    logic [ACC_W-1:0]     p_ext, r_ext, c_ext;
    logic signed [WIDE_W-1:0] mr_w, mc_w, qr_w, qc_w;

    my_project_if div_bus ();

    seq_divider u_div (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (div_bus)
    );

    function automatic logic signed [WIDE_W-1:0] widen(input logic [ACC_W-1:0] x);
        return $signed({{(WIDE_W - ACC_W){1'b0}}, x});
    endfunction

    function automatic logic [FP_TOTAL-1:0] sat_res(input logic signed [WIDE_W-1:0] v);
        if (v[WIDE_W-1]) return '0;
        if (v > SAT_V)   return SAT_V[FP_TOTAL-1:0];
        return v[FP_TOTAL-1:0];
    endfunction

    assign out_ready = {layer15_out_V_data_4_V_TREADY, layer15_out_V_data_3_V_TREADY,
                        layer15_out_V_data_2_V_TREADY, layer15_out_V_data_1_V_TREADY,
                        layer15_out_V_data_0_V_TREADY};

    always_comb begin
        pix_p    = conv2d_input_V_data_0_V_TDATA[FP_TOTAL-1] ? '0 : conv2d_input_V_data_0_V_TDATA;
        p_ext    = {{(ACC_W - FP_TOTAL){1'b0}}, pix_p};
        r_ext    = {{(ACC_W - CNT_W){1'b0}}, row_q};
        c_ext    = {{(ACC_W - CNT_W){1'b0}}, col_q};
        row_last = row_q == CNT_W'(OUT_ROWS - 1);
        col_last = col_q == CNT_W'(OUT_COLS - 1);
        s_zero   = s_q == '0;
    end

    // Next state and control; the divider runs mr, mc, qr, qc in that order.
    always_comb begin
        state_d     = state_q;
        div_start   = 1'b0;
        pix_fire    = (state_q == S_LOAD) && conv2d_input_V_data_0_V_TVALID;
        last_pix    = pix_fire && row_last && col_last;
        out_fire    = out_valid_q & out_ready;
        out_valid_d = out_valid_q & ~out_fire;
        case (state_q)
            S_IDLE:   if (ap_start) state_d = S_LOAD;
            S_LOAD:   if (last_pix) state_d = S_DIVIDE;
            S_DIVIDE: begin
                if (s_zero) begin
                    state_d = S_OUTPUT;
                end else begin
                    div_start = !div_wait_q && !div_bus.busy;
                    if (div_bus.done && div_idx_q == 2'd3) state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: if (out_valid_d == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mr_w = widen(mr_q);
        mc_w = widen(mc_q);
        qr_w = widen(qr_q);
        qc_w = widen(div_bus.quotient);
        for (int k = 0; k < NUM_RES; k++) res_d[k] = '0;
        if (!s_zero) begin
            res_d[RES_MAX] = sat_res(widen(max_q));
            res_d[RES_MR]  = sat_res(mr_w);
            res_d[RES_MC]  = sat_res(mc_w);
            res_d[RES_VR]  = sat_res(qr_w - mr_w * mr_w);
            res_d[RES_VC]  = sat_res(qc_w - mc_w * mc_w);
        end
    end

    always_comb begin
        div_bus.start   = div_start;
        div_bus.divisor = s_q;
        case (div_idx_q)
            2'd0:    div_bus.dividend = sr_q;
            2'd1:    div_bus.dividend = sc_q;
            2'd2:    div_bus.dividend = srr_q;
            default: div_bus.dividend = scc_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            row_q <= '0; col_q <= '0;
            max_q <= '0; s_q <= '0; sr_q <= '0; sc_q <= '0; srr_q <= '0; scc_q <= '0;
            mr_q <= '0; mc_q <= '0; qr_q <= '0;
            div_idx_q   <= '0;
            div_wait_q  <= 1'b0;
            out_valid_q <= '0;
            for (int k = 0; k < NUM_RES; k++) out_data_q[k] <= '0;
        end else begin
            if (state_q == S_IDLE && ap_start) begin
                row_q <= '0; col_q <= '0;
                max_q <= '0; s_q <= '0; sr_q <= '0; sc_q <= '0; srr_q <= '0; scc_q <= '0;
                div_idx_q  <= '0;
                div_wait_q <= 1'b0;
            end
            if (pix_fire) begin
                if (p_ext > max_q) max_q <= p_ext;
                s_q   <= s_q + p_ext;
                sr_q  <= sr_q + r_ext * p_ext;
                sc_q  <= sc_q + c_ext * p_ext;
                srr_q <= srr_q + r_ext * r_ext * p_ext;
                scc_q <= scc_q + c_ext * c_ext * p_ext;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + CNT_W'(1);
                end else begin
                    col_q <= col_q + CNT_W'(1);
                end
            end
            if (div_start) div_wait_q <= 1'b1;
            if (state_q == S_DIVIDE && div_bus.done) begin
                case (div_idx_q)
                    2'd0:    mr_q <= div_bus.quotient;
                    2'd1:    mc_q <= div_bus.quotient;
                    2'd2:    qr_q <= div_bus.quotient;
                    default: ;
                endcase
                div_wait_q <= 1'b0;
                div_idx_q  <= div_idx_q + 2'd1;
            end
            if (state_q == S_DIVIDE && state_d == S_OUTPUT) begin
                out_data_q  <= res_d;
                out_valid_q <= '1;
            end else if (state_q == S_OUTPUT) begin
                out_valid_q <= out_valid_d;
            end
        end
    end

    assign ap_idle  = state_q == S_IDLE;
    assign ap_ready = last_pix;
    assign ap_done  = (state_q == S_OUTPUT) && (out_valid_d == '0);
    assign conv2d_input_V_data_0_V_TREADY = state_q == S_LOAD;
    assign dbg_state = state_q;

    assign layer15_out_V_data_0_V_TDATA  = out_data_q[0];
    assign layer15_out_V_data_1_V_TDATA  = out_data_q[1];
    assign layer15_out_V_data_2_V_TDATA  = out_data_q[2];
    assign layer15_out_V_data_3_V_TDATA  = out_data_q[3];
    assign layer15_out_V_data_4_V_TDATA  = out_data_q[4];
    assign layer15_out_V_data_0_V_TVALID = out_valid_q[0];
    assign layer15_out_V_data_1_V_TVALID = out_valid_q[1];
    assign layer15_out_V_data_2_V_TVALID = out_valid_q[2];
    assign layer15_out_V_data_3_V_TVALID = out_valid_q[3];
    assign layer15_out_V_data_4_V_TVALID = out_valid_q[4];

endmodule

// File: tb/tb_my_project.sv
// Self-checking bench for my_project: frames are built in pix_mem, expected results queued,
// and the five captured output words compared once the frame reports done.
module tb_my_project;
    import my_project_pkg::*;

    localparam int W    = 16;
    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int NPIX = ROWS * COLS;
    localparam int NRES = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              ap_start = 1'b0;
    logic              ap_idle, ap_ready, ap_done;
    logic [W-1:0]      in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      out_data [NRES];
    logic [NRES-1:0]   out_valid;
    logic [NRES-1:0]   out_ready;
    state_t            dbg_state;

    my_project #(.FP_TOTAL(W), .OUT_ROWS(ROWS), .OUT_COLS(COLS)) dut (
        .ap_clk                         (clk),
        .ap_rst_n                       (rst_n),
        .ap_start                       (ap_start),
        .ap_idle                        (ap_idle),
        .ap_ready                       (ap_ready),
        .ap_done                        (ap_done),
        .conv2d_input_V_data_0_V_TDATA  (in_data),
        .conv2d_input_V_data_0_V_TVALID (in_valid),
        .conv2d_input_V_data_0_V_TREADY (in_ready),
        .layer15_out_V_data_0_V_TDATA   (out_data[0]),
        .layer15_out_V_data_1_V_TDATA   (out_data[1]),
        .layer15_out_V_data_2_V_TDATA   (out_data[2]),
        .layer15_out_V_data_3_V_TDATA   (out_data[3]),
        .layer15_out_V_data_4_V_TDATA   (out_data[4]),
        .layer15_out_V_data_0_V_TVALID  (out_valid[0]),
        .layer15_out_V_data_1_V_TVALID  (out_valid[1]),
        .layer15_out_V_data_2_V_TVALID  (out_valid[2]),
        .layer15_out_V_data_3_V_TVALID  (out_valid[3]),
        .layer15_out_V_data_4_V_TVALID  (out_valid[4]),
        .layer15_out_V_data_0_V_TREADY  (out_ready[0]),
        .layer15_out_V_data_1_V_TREADY  (out_ready[1]),
        .layer15_out_V_data_2_V_TREADY  (out_ready[2]),
        .layer15_out_V_data_3_V_TREADY  (out_ready[3]),
        .layer15_out_V_data_4_V_TREADY  (out_ready[4]),
        .dbg_state                      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0]        exp_q[$];
    logic signed [W-1:0] pix_mem [NPIX];
    int n_checks = 0;
    int n_errors = 0;
    int to_cnt = 0;
    int pix_total = 0;
    int ready_total = 0;
    int done_total = 0;
    int got_total [NRES] = '{default: 0};
    logic [W-1:0] got_val [NRES] = '{default: '0};
    bit rand_in = 1'b0;
    bit rand_out = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Monitor samples on the falling edge, between the edges that move DUT state.
    always @(negedge clk) begin
        if (in_valid && in_ready) pix_total++;
        if (ap_ready) ready_total++;
        if (ap_done) done_total++;
        for (int k = 0; k < NRES; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                got_total[k]++;
                got_val[k] = out_data[k];
            end
        end
    end

    initial begin
        out_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NRES; k++)
                out_ready[k] = rand_out ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // ---------------- stimulus / model ----------------
    task automatic fill_frame(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            int r;
            int c;
            r = i / COLS;
            c = i % COLS;
            case (kind)
                0: pix_mem[i] = (r == 10 && c == 20) ? 16'sd100 : 16'sd0;
                1: pix_mem[i] = 16'sd0;
                2: pix_mem[i] = (r == 0 && (c == 0 || c == 2)) ? 16'sd50 : 16'sd0;
                3: pix_mem[i] = (r == 47 && c == 47) ? 16'sd7 : -16'sd5;
                4: pix_mem[i] = (c == 0 && (r == 0 || r == 4)) ? 16'sd10 : 16'sd0;
                default: pix_mem[i] = 16'(int'($urandom_range(40000, 0)) - 8000);
            endcase
        end
    endtask

    task automatic push_exp5(input int a, input int b, input int c, input int d, input int e);
        exp_q.push_back(W'(a)); exp_q.push_back(W'(b)); exp_q.push_back(W'(c));
        exp_q.push_back(W'(d)); exp_q.push_back(W'(e));
    endtask

    function automatic int sat16(input longint v);
        if (v < 0) return 0;
        if (v > 32767) return 32767;
        return int'(v);
    endfunction

    task automatic push_model();
        longint s = 0, sr = 0, sc = 0, srr = 0, scc = 0, mx = 0;
        longint p, mr, mc, qr, qc;
        for (int i = 0; i < NPIX; i++) begin
            longint r;
            longint c;
            r = i / COLS;
            c = i % COLS;
            p = (pix_mem[i] < 0) ? 0 : longint'(pix_mem[i]);
            if (p > mx) mx = p;
            s += p; sr += r * p; sc += c * p; srr += r * r * p; scc += c * c * p;
        end
        if (s == 0) begin
            push_exp5(0, 0, 0, 0, 0);
        end else begin
            mr = sr / s; mc = sc / s; qr = srr / s; qc = scc / s;
            push_exp5(sat16(mx), sat16(mr), sat16(mc), sat16(qr - mr * mr), sat16(qc - mc * mc));
        end
    endtask

    task automatic drive_pixel(input logic [W-1:0] pix);
        int guard = 0;
        bit acc = 1'b0;
        if (rand_in) begin
            while ($urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_data  = pix;
        in_valid = 1'b1;
        while (!acc && guard < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) to_cnt++;
    endtask

    task automatic start_frame();
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic run_frame(input string name, input bit ri, input bit ro, input bit mid_start);
        int p0, r0, d0, guard;
        int g0 [NRES];
        logic [W-1:0] e;
        rand_in  = ri;
        rand_out = ro;
        to_cnt   = 0;
        check_eq({name, "_idle_pre"}, ap_idle, 1);
        p0 = pix_total; r0 = ready_total; d0 = done_total;
        for (int k = 0; k < NRES; k++) g0[k] = got_total[k];
        start_frame();
        for (int i = 0; i < NPIX && to_cnt == 0; i++) begin
            if (mid_start) ap_start = (i == 500);
            drive_pixel(pix_mem[i]);
        end
        ap_start = 1'b0;
        guard = 0;
        while (done_total == d0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq({name, "_done_seen"}, done_total != d0, 1);
        check_eq({name, "_pix_timeouts"}, to_cnt, 0);
        for (int k = 0; k < NRES; k++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s_out%0d", name, k), got_val[k], e);
            check_eq($sformatf("%s_out%0d_count", name, k), got_total[k] - g0[k], 1);
        end
        check_eq({name, "_pixels"}, pix_total - p0, NPIX);
        check_eq({name, "_ready_pulses"}, ready_total - r0, 1);
        check_eq({name, "_done_pulses"}, done_total - d0, 1);
        check_eq({name, "_idle_post"}, ap_idle, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_idle"}, ap_idle, 1);
        check_eq({name, "_state"}, 64'(dbg_state), 64'(S_IDLE));
        check_eq({name, "_in_ready"}, in_ready, 0);
        check_eq({name, "_ready"}, ap_ready, 0);
        check_eq({name, "_done"}, ap_done, 0);
        check_eq({name, "_valids"}, out_valid, 0);
        for (int k = 0; k < NRES; k++)
            check_eq($sformatf("%s_tdata%0d", name, k), out_data[k], 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, gsum0, gsum1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill_frame(0); push_exp5(100, 10, 20, 0, 0);  run_frame("single", 0, 0, 0);
        fill_frame(1); push_exp5(0, 0, 0, 0, 0);      run_frame("zero", 0, 0, 0);
        fill_frame(2); push_exp5(50, 0, 1, 0, 1);     run_frame("pair", 0, 0, 0);
        fill_frame(3); push_exp5(7, 47, 47, 0, 0);    run_frame("negbg", 0, 0, 0);
        fill_frame(4); push_exp5(10, 2, 0, 4, 0);     run_frame("rowvar", 0, 0, 0);
        fill_frame(0); push_exp5(100, 10, 20, 0, 0);  run_frame("single_rand", 1, 1, 0);
        fill_frame(5); push_model();                  run_frame("random", 1, 1, 0);

        // Abort a frame part-way with reset; nothing may come out of it.
        fill_frame(0);
        rand_in = 1'b0;
        rand_out = 1'b0;
        to_cnt = 0;
        d0 = done_total;
        gsum0 = 0;
        for (int k = 0; k < NRES; k++) gsum0 += got_total[k];
        start_frame();
        for (int i = 0; i < 1000 && to_cnt == 0; i++) drive_pixel(pix_mem[i]);
        check_eq("abort_pix_timeouts", to_cnt, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        gsum1 = 0;
        for (int k = 0; k < NRES; k++) gsum1 += got_total[k];
        check_eq("abort_no_done", done_total - d0, 0);
        check_eq("abort_no_output", gsum1 - gsum0, 0);

        fill_frame(2); push_exp5(50, 0, 1, 0, 1);     run_frame("after_abort", 0, 0, 1);

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
